// File: rtl/neuron_array_tdm.sv
// Time-multiplexed leaky integrate-and-fire neuron array: one shared update datapath
// walks all N neurons per time step and publishes the spike vector atomically.
module neuron_array_tdm #(
   parameter int N          = 16,
   parameter int W          = 16,
   parameter int WI         = 8,
   parameter int LEAK_SHIFT = 2,
   parameter int REFRACT    = 2,
   localparam int AW        = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 step_start,
   input  logic signed [W-1:0]  threshold,
   input  logic                 force_spike_en,
   input  logic [AW-1:0]        force_spike_neuron_select,
   output logic [AW-1:0]        cur_addr,
   input  logic signed [WI-1:0] cur_data,
   output logic                 busy,
   output logic                 step_done,
   output logic [N-1:0]         spike_out
);

   localparam int RW = (REFRACT == 0) ? 1 : $clog2(REFRACT + 1);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t               state;
   logic [AW-1:0]        idx;
   logic                 vld_p1;
   logic [AW-1:0]        idx_p1;
   logic signed [W-1:0]  thr_q;
   logic                 force_en_q;
   logic [AW-1:0]        force_sel_q;
   logic signed [W-1:0]  v_mem [N];
   logic [RW-1:0]        r_mem [N];
   logic [N-1:0]         spike_next;

   logic signed [W-1:0]  v_cur;
   logic [RW-1:0]        r_cur;
   logic signed [W-1:0]  v_leak;
   logic signed [W:0]    sum_wide;
   logic signed [W-1:0]  sum_sat;
   logic                 forced;
   logic                 spike_upd;
   logic signed [W-1:0]  v_upd;
   logic [RW-1:0]        r_upd;
   logic [N-1:0]         spike_vec;

   function automatic logic signed [W-1:0] leak(input logic signed [W-1:0] v);
      if (LEAK_SHIFT == 0) return v;
      return v - (v >>> LEAK_SHIFT);
   endfunction

   function automatic logic signed [W-1:0] sat_w(input logic signed [W:0] x);
      if (x[W] != x[W-1]) return x[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      return x[W-1:0];
   endfunction

   assign cur_addr = idx;

   // Stage p1: neuron addressed last cycle is updated with the current arriving now
   always_comb begin
      v_cur     = v_mem[idx_p1];
      r_cur     = r_mem[idx_p1];
      forced    = force_en_q && (force_sel_q == idx_p1);
      v_leak    = leak(v_cur);
      sum_wide  = {v_leak[W-1], v_leak} + {{(W+1-WI){cur_data[WI-1]}}, cur_data};
      sum_sat   = sat_w(sum_wide);
      spike_upd = 1'b0;
      v_upd     = sum_sat;
      r_upd     = r_cur;
      if (forced) begin
         spike_upd = 1'b1;
         v_upd     = '0;
         r_upd     = RW'(REFRACT);
      end else if (r_cur != '0) begin
         v_upd = '0;
         r_upd = r_cur - RW'(1);
      end else if (sum_sat >= thr_q) begin
         spike_upd = 1'b1;
         v_upd     = '0;
         r_upd     = RW'(REFRACT);
      end
      spike_vec         = spike_next;
      spike_vec[idx_p1] = spike_upd;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         idx         <= '0;
         vld_p1      <= 1'b0;
         idx_p1      <= '0;
         busy        <= 1'b0;
         step_done   <= 1'b0;
         spike_out   <= '0;
         spike_next  <= '0;
         thr_q       <= '0;
         force_en_q  <= 1'b0;
         force_sel_q <= '0;
         for (int i = 0; i < N; i++) begin
            v_mem[i] <= '0;
            r_mem[i] <= '0;
         end
      end else begin
         vld_p1    <= (state == RUN);
         idx_p1    <= idx;
         step_done <= 1'b0;
         if (vld_p1) begin
            v_mem[idx_p1] <= v_upd;
            r_mem[idx_p1] <= r_upd;
            spike_next    <= spike_vec;
         end
         case (state)
            IDLE: begin
               if (step_start) begin
                  thr_q       <= threshold;
                  force_en_q  <= force_spike_en;
                  force_sel_q <= force_spike_neuron_select;
                  idx         <= '0;
                  busy        <= 1'b1;
                  state       <= RUN;
               end
            end
            RUN: begin
               if (idx == AW'(N - 1)) begin
                  idx   <= '0;
                  state <= FLUSH;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            FLUSH: begin
               spike_out <= spike_vec;
               step_done <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/neuron_array_tdm.md
# neuron_array_tdm

Time-multiplexed array of N leaky integrate-and-fire neurons. A single shared update datapath replaces per-neuron logic and walks all neurons once per network time step. Membrane potentials and refractory counters live in internal state. The block fetches each neuron's summed synaptic current from an external synapse stage over an address/data port with one-cycle read latency. It then publishes the full spike vector atomically at the end of the step, with per-neuron forced spiking for stimulus injection. It sits between the synapse accumulation stage and the next layer's spike input.

## Interface
- N, 16: number of neurons (≥2)
- W, 16: membrane potential width, signed
- WI, 8: input current width, signed (WI ≤ W)
- LEAK_SHIFT, 2: leak is v − (v >>> LEAK_SHIFT); 0 disables leak (pure IF mode)
- REFRACT, 2: refractory steps after a spike; 0 disables refractory
- AW, $clog2(N): address width (derived)

- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- step_start  in  1  pulse: begin one time step; ignored while busy
- threshold  in  W  signed firing threshold, latched at accepted step_start
- force_spike_en  in  1  latched at accepted step_start
- force_spike_neuron_select  in  AW  neuron to force, latched with force_spike_en
- cur_addr  out  AW  neuron index whose current is requested
- cur_data  in  WI  signed current for the address presented the previous cycle
- busy  out  1  high from the cycle after an accepted step_start through the step_done cycle
- step_done  out  1  one-cycle pulse; spike_out holds the new vector in this cycle
- spike_out  out  N  registered spike vector of the last completed step

## Operation
- States:
  - IDLE: accepted step_start → RUN with idx=0.
  - RUN: cur_addr=idx, idx increments each cycle; idx=N−1 → FLUSH.
  - FLUSH: final neuron update; spike_out ← spike_next → DONE.
  - DONE: step_done=1 → IDLE.
- Update pipeline: the neuron addressed in cycle c is updated at the end of cycle c+1 using cur_data sampled in c+1.
- Per-neuron update, with forced = latched force_en & (latched sel == neuron):
  - If forced: spike=1, v←0, r←REFRACT. This applies regardless of refractory state or input.
  - Else if r>0: spike=0, v←0, r←r−1. Input is discarded.
  - Else: vl = LEAK_SHIFT ? v − (v >>> LEAK_SHIFT) : v, with arithmetic shift. sum = vl + sign-extended cur_data, computed at W+1 bits and saturated to the signed W range. If sum ≥ threshold (signed compare): spike=1, v←0, r←REFRACT. Otherwise spike=0, v←sum.
- spike_next is assembled bitwise during RUN/FLUSH. spike_out changes only at the FLUSH→DONE edge, never partially.
- cur_addr outside RUN is held at 0.
- Refractory counters are $clog2(REFRACT+1) bits, minimum 1.
- reset in any state:
  - State → IDLE.
  - All v, r, spike_next, spike_out → 0.
  - busy and step_done → 0, and cur_addr → 0.
  - An aborted step produces no step_done.

## Timing
- step_start sampled high in IDLE at cycle 0.
- RUN occupies cycles 1..N, with cur_addr = 0..N−1.
- FLUSH occurs in cycle N+1.
- DONE occurs in cycle N+2: step_done=1 and the new spike_out is visible.
- busy is high in cycles 1..N+2. The next step_start can be accepted in cycle N+3, giving a throughput of one step per N+3 cycles.
- step_start in cycles 1..N+2 is ignored and has no queued effect.
- The external synapse stage must drive cur_data for cur_addr=k in the cycle after k is presented. For k=N−1 that cycle is FLUSH.
- Reset values: busy=0, step_done=0, spike_out=0, cur_addr=0.

## Test plan
Unless noted, use N=4, W=16, WI=8, LEAK_SHIFT=2, REFRACT=2, threshold=100.

- **Integration:** cur_data=40 for neuron 0 and 0 for others, each step.
  - Expected v sequence: 40, 70, 93.
  - spike_out=4'b0001 in step 4; all other steps are 0.
- **Refractory:** continue the previous stimulus.
  - Steps 5 and 6: spike_out=0, v held at 0.
  - Step 7: v=40, no spike. Step 10: spike again.
- **Force:** force_spike_en=1, select=2, all currents 0.
  - spike_out=4'b0100 in that step.
  - Force during refractory also spikes and restarts REFRACT.
- **Saturation:** instance with LEAK_SHIFT=0 and threshold=0.
  - Apply cur_data=−128 for 300 steps: v clamps at −32768, no spike.
  - Then apply +127 per step: the first spike occurs on the 259th step. An earlier spike indicates wrap-around.
- **Handshake/timing:**
  - Single step_start: cur_addr 0,1,2,3 in cycles 1–4; step_done only in cycle 6; busy high in cycles 1–6.
  - step_start pulsed in cycle 3: no second step.
- **Reset mid-step:** assert reset in cycle 2 of a step that would spike neuron 0.
  - Next cycle: busy=0, spike_out=0, no step_done.
  - The following step starts from v=0 for all neurons.
